// File: rtl/noc_params.sv
// Shared NoC router definitions: flit format, flit types, VC FSM states and
// the widths derived from the default router geometry.
//   VC_SIZE    - bits needed to name a virtual channel
//   PORT_SIZE  - bits needed to name a router port
//   flit_t     - {flit_type, vc_id, data}
package noc_params;

    localparam int unsigned VC_NUM_DEFAULT      = 2;
    localparam int unsigned PORT_NUM_DEFAULT    = 5;
    localparam int unsigned BUFFER_SIZE_DEFAULT = 8;

    localparam int unsigned VC_SIZE        = (VC_NUM_DEFAULT > 1) ? $clog2(VC_NUM_DEFAULT) : 1;
    localparam int unsigned PORT_SIZE      = $clog2(PORT_NUM_DEFAULT);
    localparam int unsigned FLIT_DATA_SIZE = 16;

    typedef enum logic [1:0] {
        HEAD     = 2'b00,
        BODY     = 2'b01,
        TAIL     = 2'b10,
        HEADTAIL = 2'b11
    } flit_type_t;

    typedef struct packed {
        flit_type_t                flit_type;
        logic [VC_SIZE-1:0]        vc_id;
        logic [FLIT_DATA_SIZE-1:0] data;
    } flit_t;

    typedef enum logic [1:0] {
        StIdle,
        StVa,
        StActive
    } vc_state_e;

    // A flit that opens a packet (needs VC allocation before it can move).
    function automatic logic is_head(flit_type_t t);
        return (t == HEAD) || (t == HEADTAIL);
    endfunction

    // A flit that closes a packet (releases the VC once popped).
    function automatic logic is_tail(flit_type_t t);
        return (t == TAIL) || (t == HEADTAIL);
    endfunction

endpackage

// File: rtl/input_vc_controller_if.sv
// Bus bundle of the input VC controller.
//   master : upstream link / allocators / crossbar side (drives *_i)
//   slave  : the input VC controller itself (drives *_o)
// Signals: write port (wr_valid_i, wr_vc_i, wr_flit_i, wr_out_port_i),
// VC allocation (vc_request_o, out_port_o, vc_valid_i, vc_new_i, downstream_vc_o),
// switch allocation / read (sa_request_o, rd_grant_i, rd_flit_o),
// status (idle_o, err_o).
interface input_vc_controller_if #(
    parameter int unsigned VC_NUM = noc_params::VC_NUM_DEFAULT
);
    import noc_params::*;

    logic                              wr_valid_i;
    logic [VC_SIZE-1:0]                wr_vc_i;
    flit_t                             wr_flit_i;
    logic [PORT_SIZE-1:0]              wr_out_port_i;

    logic [VC_NUM-1:0]                 vc_request_o;
    logic [VC_NUM-1:0][PORT_SIZE-1:0]  out_port_o;
    logic [VC_NUM-1:0]                 vc_valid_i;
    logic [VC_NUM-1:0][VC_SIZE-1:0]    vc_new_i;
    logic [VC_NUM-1:0][VC_SIZE-1:0]    downstream_vc_o;

    logic [VC_NUM-1:0]                 sa_request_o;
    logic [VC_NUM-1:0]                 rd_grant_i;
    flit_t                             rd_flit_o;

    logic [VC_NUM-1:0]                 idle_o;
    logic                              err_o;

    modport master (
        output wr_valid_i, wr_vc_i, wr_flit_i, wr_out_port_i,
        output vc_valid_i, vc_new_i, rd_grant_i,
        input  vc_request_o, out_port_o, downstream_vc_o, sa_request_o,
        input  rd_flit_o, idle_o, err_o
    );

    modport slave (
        input  wr_valid_i, wr_vc_i, wr_flit_i, wr_out_port_i,
        input  vc_valid_i, vc_new_i, rd_grant_i,
        output vc_request_o, out_port_o, downstream_vc_o, sa_request_o,
        output rd_flit_o, idle_o, err_o
    );

endinterface

// File: rtl/ivc_fifo.sv
// Per-VC flit buffer: DEPTH entries of WIDTH bits, first-word fall-through
// (a write at cycle N is at the front at N+1).
// Ports:
//   clk, rst          - clock, synchronous active-high reset (empties the FIFO)
//   wr_en, wr_data    - push request; dropped when full unless popped the same cycle
//   rd_en             - pop request; ignored when empty
//   rd_data           - front entry (undefined when empty)
//   empty, full       - occupancy flags
module ivc_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic             full
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q;
    logic [PtrW-1:0]  rd_ptr_q;
    logic [PtrW:0]    count_q;
    logic             push;
    logic             pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == (PtrW + 1)'(DEPTH));
    assign pop     = rd_en && !empty;
    // A pop frees the slot in the same cycle, so a full FIFO still accepts.
    assign push    = wr_en && (!full || pop);
    assign rd_data = mem_q[rd_ptr_q];

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + (PtrW + 1)'(1);
                2'b01:   count_q <= count_q - (PtrW + 1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage is not reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: rtl/input_vc_controller.sv
// Router input-port VC controller: buffers incoming flits per virtual channel,
// runs the per-VC IDLE -> VA -> ACTIVE packet FSM, raises VA and SA requests
// and presents the granted VC's front flit with its downstream VC id.
// Ports:
//   clk  - clock
//   rst  - synchronous active-high reset; discards all buffered flits
//   bus  - input_vc_controller_if.slave (write, VA, SA/read and status signals)
// Optional build macro IVC_ERR_FLAG_EN: enables the sticky err_o flag
// (write to a full VC, vc_valid_i outside VA, multi-hot rd_grant_i).
// Without it err_o is tied low.
module input_vc_controller
    import noc_params::*;
#(
    parameter int unsigned VC_NUM      = VC_NUM_DEFAULT,
    parameter int unsigned BUFFER_SIZE = BUFFER_SIZE_DEFAULT,
    parameter int unsigned PORT_NUM    = PORT_NUM_DEFAULT
) (
    input logic                  clk,
    input logic                  rst,
    input_vc_controller_if.slave bus
);

    if ((BUFFER_SIZE < 2) || ((BUFFER_SIZE & (BUFFER_SIZE - 1)) != 0)) begin : g_bad_buffer_size
        $error("BUFFER_SIZE must be a power of two, at least 2");
    end
    if (VC_NUM > (1 << VC_SIZE)) begin : g_bad_vc_num
        $error("VC_NUM does not fit in noc_params::VC_SIZE");
    end
    if (PORT_NUM > (1 << PORT_SIZE)) begin : g_bad_port_num
        $error("PORT_NUM does not fit in noc_params::PORT_SIZE");
    end

    typedef struct packed {
        flit_t                flit;
        logic [PORT_SIZE-1:0] out_port;
    } entry_t;

    vc_state_e [VC_NUM-1:0]          state_q;
    vc_state_e [VC_NUM-1:0]          state_d;
    logic [VC_NUM-1:0][VC_SIZE-1:0]  downstream_vc_q;
    logic [VC_NUM-1:0][VC_SIZE-1:0]  downstream_vc_d;
    logic [VC_NUM-1:0]               idle_q;

    entry_t                          wr_entry;
    entry_t [VC_NUM-1:0]             front;
    logic [VC_NUM-1:0]               fifo_wr;
    logic [VC_NUM-1:0]               fifo_pop;
    logic [VC_NUM-1:0]               fifo_empty;
    logic [VC_NUM-1:0]               fifo_full;
    logic [VC_NUM-1:0]               vc_request;
    logic [VC_NUM-1:0]               sa_request;
    flit_t                           rd_flit;

    assign wr_entry = '{flit: bus.wr_flit_i, out_port: bus.wr_out_port_i};

    for (genvar v = 0; v < VC_NUM; v++) begin : g_vc
        assign fifo_wr[v]        = bus.wr_valid_i && (bus.wr_vc_i == VC_SIZE'(v));
        assign vc_request[v]     = (state_q[v] == StVa);
        assign sa_request[v]     = (state_q[v] == StActive) && !fifo_empty[v];
        assign bus.out_port_o[v] = front[v].out_port;

        ivc_fifo #(
            .DEPTH (BUFFER_SIZE),
            .WIDTH ($bits(entry_t))
        ) u_fifo (
            .clk     (clk),
            .rst     (rst),
            .wr_en   (fifo_wr[v]),
            .wr_data (wr_entry),
            .rd_en   (fifo_pop[v]),
            .rd_data (front[v]),
            .empty   (fifo_empty[v]),
            .full    (fifo_full[v])
        );
    end

    // Grants to a VC that is not requesting are ignored.
    assign fifo_pop = bus.rd_grant_i & sa_request;

    always_comb begin
        state_d         = state_q;
        downstream_vc_d = downstream_vc_q;
        for (int v = 0; v < int'(VC_NUM); v++) begin
            case (state_q[v])
                StIdle: begin
                    if (!fifo_empty[v] && is_head(front[v].flit.flit_type)) begin
                        state_d[v] = StVa;
                    end
                end
                StVa: begin
                    if (bus.vc_valid_i[v]) begin
                        state_d[v]         = StActive;
                        downstream_vc_d[v] = bus.vc_new_i[v];
                    end
                end
                StActive: begin
                    if (fifo_pop[v] && is_tail(front[v].flit.flit_type)) begin
                        state_d[v] = StIdle;
                    end
                end
                default: state_d[v] = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int v = 0; v < int'(VC_NUM); v++) begin
                state_q[v] <= StIdle;
            end
            downstream_vc_q <= '0;
            idle_q          <= '1;
        end else begin
            state_q         <= state_d;
            downstream_vc_q <= downstream_vc_d;
            for (int v = 0; v < int'(VC_NUM); v++) begin
                idle_q[v] <= (state_q[v] == StIdle) && fifo_empty[v];
            end
        end
    end

    // The flit leaving the crossbar carries the downstream VC id, not the local one.
    always_comb begin
        rd_flit = '0;
        for (int v = 0; v < int'(VC_NUM); v++) begin
            if (bus.rd_grant_i[v]) begin
                rd_flit       = front[v].flit;
                rd_flit.vc_id = downstream_vc_q[v];
            end
        end
    end

    assign bus.vc_request_o    = vc_request;
    assign bus.sa_request_o    = sa_request;
    assign bus.downstream_vc_o = downstream_vc_q;
    assign bus.idle_o          = idle_q;
    assign bus.rd_flit_o       = rd_flit;

`ifdef IVC_ERR_FLAG_EN
    logic err_q;
    logic err_d;
    logic grant_multi;

    assign grant_multi = (bus.rd_grant_i & (bus.rd_grant_i - VC_NUM'(1))) != '0;

    always_comb begin
        err_d = err_q;
        // Only writes that are actually lost count; a full VC popped this cycle accepts.
        if ((fifo_wr & fifo_full & ~fifo_pop) != '0) begin
            err_d = 1'b1;
        end
        if ((bus.vc_valid_i & ~vc_request) != '0) begin
            err_d = 1'b1;
        end
        if (grant_multi) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign bus.err_o = err_q;
`else
    // Fullness only matters for error reporting; drops happen inside the FIFO.
    logic unused_fifo_full;
    assign unused_fifo_full = ^fifo_full;
    assign bus.err_o        = 1'b0;
`endif

endmodule

// File: tb/tb_input_vc_controller.sv
// Self-checking bench for input_vc_controller: directed scenarios followed by
// randomized traffic, all checked against a queue-based packet model.
module tb_input_vc_controller;
    import noc_params::*;

    localparam int unsigned NV = 2;
    localparam int unsigned BS = 8;
    localparam int M_IDLE = 0;
    localparam int M_VA   = 1;
    localparam int M_ACT  = 2;
`ifdef IVC_ERR_FLAG_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    typedef struct {
        flit_t                f;
        logic [PORT_SIZE-1:0] p;
    } ent_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    input_vc_controller_if #(.VC_NUM(NV)) bus ();

    input_vc_controller #(
        .VC_NUM      (NV),
        .BUFFER_SIZE (BS),
        .PORT_NUM    (5)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Reference model: one flit queue per VC plus the packet phase of each VC.
    ent_t               mq [NV][$];
    int                 mst [NV];
    logic [VC_SIZE-1:0] mdvc [NV];
    logic [NV-1:0]      midle;
    logic               merr;

    int n_cmp;
    int n_mis;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int v = 0; v < int'(NV); v++) begin
            mq[v].delete();
            mst[v]  = M_IDLE;
            mdvc[v] = '0;
        end
        midle = '1;
        merr  = 1'b0;
    endtask

    function automatic logic [NV-1:0] model_sa();
        logic [NV-1:0] s;
        for (int v = 0; v < int'(NV); v++) begin
            s[v] = (mst[v] == M_ACT) && (mq[v].size() > 0);
        end
        return s;
    endfunction

    task automatic model_step(input logic [NV-1:0] pops);
        int            nst [NV];
        logic [NV-1:0] nidle;
        flit_type_t    ft;
        ent_t          e;
        int            w;
        if (rst) begin
            model_reset();
            return;
        end
        for (int v = 0; v < int'(NV); v++) begin
            nidle[v] = (mst[v] == M_IDLE) && (mq[v].size() == 0);
            nst[v]   = mst[v];
            ft       = (mq[v].size() > 0) ? mq[v][0].f.flit_type : BODY;
            if (mst[v] == M_IDLE && mq[v].size() > 0 && (ft == HEAD || ft == HEADTAIL)) begin
                nst[v] = M_VA;
            end else if (mst[v] == M_VA && bus.vc_valid_i[v]) begin
                nst[v]  = M_ACT;
                mdvc[v] = bus.vc_new_i[v];
            end else if (mst[v] == M_ACT && pops[v] && (ft == TAIL || ft == HEADTAIL)) begin
                nst[v] = M_IDLE;
            end
            if (ERR_EN && bus.vc_valid_i[v] && mst[v] != M_VA) merr = 1'b1;
        end
        if (ERR_EN && $countones(bus.rd_grant_i) > 1) merr = 1'b1;
        for (int v = 0; v < int'(NV); v++) begin
            if (pops[v]) void'(mq[v].pop_front());
        end
        if (bus.wr_valid_i) begin
            w = int'(bus.wr_vc_i);
            if (mq[w].size() < int'(BS)) begin
                e.f = bus.wr_flit_i;
                e.p = bus.wr_out_port_i;
                mq[w].push_back(e);
            end else if (ERR_EN) begin
                merr = 1'b1;
            end
        end
        for (int v = 0; v < int'(NV); v++) mst[v] = nst[v];
        midle = nidle;
    endtask

    task automatic clear_inputs();
        bus.wr_valid_i    = 1'b0;
        bus.wr_vc_i       = '0;
        bus.wr_flit_i     = '0;
        bus.wr_out_port_i = '0;
        bus.vc_valid_i    = '0;
        bus.vc_new_i      = '0;
        bus.rd_grant_i    = '0;
    endtask

    task automatic set_write(input int vc, input flit_type_t t, input logic [15:0] d,
                             input logic [PORT_SIZE-1:0] p);
        flit_t f;
        f.flit_type       = t;
        f.vc_id           = '0;
        f.data            = d;
        bus.wr_valid_i    = 1'b1;
        bus.wr_vc_i       = VC_SIZE'(vc);
        bus.wr_flit_i     = f;
        bus.wr_out_port_i = p;
    endtask

    // Called just after a falling edge with inputs set: checks outputs, clocks, updates model.
    task automatic tick();
        logic [NV-1:0] ereq;
        logic [NV-1:0] esa;
        logic [NV-1:0] pops;
        flit_t         ef;
        #1;
        esa = model_sa();
        for (int v = 0; v < int'(NV); v++) ereq[v] = (mst[v] == M_VA);
        check("vc_request", 32'(bus.vc_request_o), 32'(ereq));
        check("sa_request", 32'(bus.sa_request_o), 32'(esa));
        check("idle", 32'(bus.idle_o), 32'(midle));
        check("err", 32'(bus.err_o), 32'(merr));
        for (int v = 0; v < int'(NV); v++) begin
            check($sformatf("downstream_vc%0d", v), 32'(bus.downstream_vc_o[v]), 32'(mdvc[v]));
            if (mq[v].size() > 0) begin
                check($sformatf("out_port%0d", v), 32'(bus.out_port_o[v]), 32'(mq[v][0].p));
            end
        end
        pops = bus.rd_grant_i & esa;
        if ($countones(bus.rd_grant_i) == 1 && pops != '0) begin
            for (int v = 0; v < int'(NV); v++) begin
                if (pops[v]) begin
                    ef       = mq[v][0].f;
                    ef.vc_id = mdvc[v];
                    check("rd_flit", 32'(bus.rd_flit_o), 32'(ef));
                end
            end
        end
        @(posedge clk);
        model_step(pops);
        @(negedge clk);
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        logic [NV-1:0] esa;
        int            idx;
        int            r;
        n_cmp = 0;
        n_mis = 0;
        clear_inputs();
        rst = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("reset_idle", 32'(bus.idle_o), 32'h3);
        check("reset_err", 32'(bus.err_o), 32'h0);
        check("reset_dvc", 32'(bus.downstream_vc_o), 32'h0);
        check("reset_req", 32'({bus.vc_request_o, bus.sa_request_o}), 32'h0);

        // HEADTAIL lifecycle on VC0.
        clear_inputs(); set_write(0, HEADTAIL, 16'hA001, 3); tick();
        clear_inputs(); tick();
        check("va_at_cycle2", 32'(bus.vc_request_o[0]), 32'h1);
        clear_inputs(); bus.vc_valid_i = 2'b01; bus.vc_new_i[0] = 1'b1; tick();
        check("sa_after_grant", 32'(bus.sa_request_o[0]), 32'h1);
        check("dvc_latched", 32'(bus.downstream_vc_o[0]), 32'h1);
        clear_inputs(); bus.rd_grant_i = 2'b01; tick();
        check("idle_one_after_pop", 32'(bus.idle_o[0]), 32'h0);
        clear_inputs(); tick();
        check("idle_two_after_pop", 32'(bus.idle_o[0]), 32'h1);

        // Overfill VC1: ninth write dropped.
        do_reset();
        for (int i = 0; i < 9; i++) begin
            clear_inputs();
            set_write(1, (i == 0) ? HEAD : ((i == 8) ? TAIL : BODY), 16'h0100 + 16'(i), 2);
            tick();
        end
        check("overfill_err", 32'(bus.err_o), 32'(ERR_EN));
        clear_inputs(); bus.vc_valid_i = 2'b10; tick();
        for (int i = 0; i < 8; i++) begin
            clear_inputs(); bus.rd_grant_i = 2'b10; tick();
        end
        check("overfill_drained_at8", 32'(bus.sa_request_o[1]), 32'h0);
        check("overfill_still_active", 32'(bus.vc_request_o[1]), 32'h0);

        // Full VC0 with write and pop together for 20 cycles.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            clear_inputs(); set_write(0, (i == 0) ? HEAD : BODY, 16'h0200 + 16'(i), 1); tick();
        end
        clear_inputs(); bus.vc_valid_i = 2'b01; tick();
        for (int i = 0; i < 20; i++) begin
            clear_inputs();
            set_write(0, BODY, 16'h0300 + 16'(i), PORT_SIZE'(i % 5));
            bus.rd_grant_i = 2'b01;
            tick();
        end
        check("full_wr_pop_sa", 32'(bus.sa_request_o[0]), 32'h1);
        for (int i = 0; i < 8; i++) begin
            clear_inputs(); bus.rd_grant_i = 2'b01; tick();
        end
        check("full_wr_pop_count8", 32'(bus.sa_request_o[0]), 32'h0);

        // Back-to-back packets on VC0.
        do_reset();
        clear_inputs(); set_write(0, HEAD, 16'h0401, 3); tick();
        clear_inputs(); set_write(0, BODY, 16'h0402, 3); tick();
        clear_inputs(); set_write(0, TAIL, 16'h0403, 3); tick();
        clear_inputs(); set_write(0, HEAD, 16'h0404, 4); tick();
        clear_inputs(); bus.vc_valid_i = 2'b01; tick();
        for (int i = 0; i < 3; i++) begin
            clear_inputs(); bus.rd_grant_i = 2'b01; tick();
        end
        check("b2b_new_port", 32'(bus.out_port_o[0]), 32'h4);
        check("b2b_passes_idle", 32'(bus.vc_request_o[0]), 32'h0);
        check("b2b_idle_low0", 32'(bus.idle_o[0]), 32'h0);
        clear_inputs(); tick();
        check("b2b_then_va", 32'(bus.vc_request_o[0]), 32'h1);
        check("b2b_idle_low1", 32'(bus.idle_o[0]), 32'h0);

        // vc_valid to an idle VC is ignored.
        do_reset();
        clear_inputs(); bus.vc_valid_i = 2'b10; bus.vc_new_i[1] = 1'b1; tick();
        check("stray_valid_dvc", 32'(bus.downstream_vc_o[1]), 32'h0);
        check("stray_valid_state", 32'({bus.vc_request_o[1], bus.sa_request_o[1]}), 32'h0);
        check("stray_valid_err", 32'(bus.err_o), 32'(ERR_EN));

        // Reset mid-packet with 3 flits buffered.
        do_reset();
        clear_inputs(); set_write(0, HEAD, 16'h0501, 2); tick();
        clear_inputs(); set_write(0, BODY, 16'h0502, 2); tick();
        clear_inputs(); set_write(0, BODY, 16'h0503, 2); tick();
        clear_inputs(); bus.vc_valid_i = 2'b01; bus.vc_new_i[0] = 1'b1; tick();
        check("pre_reset_active", 32'(bus.sa_request_o[0]), 32'h1);
        clear_inputs(); rst = 1'b1; tick(); rst = 1'b0;
        check("midrst_req", 32'({bus.vc_request_o, bus.sa_request_o}), 32'h0);
        check("midrst_idle", 32'(bus.idle_o), 32'h3);
        check("midrst_dvc", 32'(bus.downstream_vc_o), 32'h0);
        clear_inputs(); tick(); tick();
        check("midrst_empty", 32'(bus.vc_request_o), 32'h0);

        // Randomized traffic.
        do_reset();
        repeat (3000) begin
            clear_inputs();
            if ($urandom_range(99) < 60) begin
                set_write(int'($urandom_range(NV - 1)), flit_type_t'($urandom_range(3)),
                          16'($urandom), PORT_SIZE'($urandom_range(4)));
            end
            for (int v = 0; v < int'(NV); v++) begin
                bus.vc_valid_i[v] = ($urandom_range(99) < 30);
                bus.vc_new_i[v]   = VC_SIZE'($urandom_range(1));
            end
            esa = model_sa();
            r   = int'($urandom_range(99));
            if (r < 70 && esa != '0) begin
                do idx = int'($urandom_range(NV - 1)); while (!esa[idx]);
                bus.rd_grant_i = NV'(1) << idx;
            end else if (r < 85) begin
                bus.rd_grant_i = NV'(1) << $urandom_range(NV - 1);
            end
            rst = ($urandom_range(299) == 0);
            tick();
        end
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/input_vc_controller.md
INPUT_VC_CONTROLLER -- requirements
Module: input_vc_controller

Interface
REQ-001 SHALL have parameter VC_NUM, default 2, virtual channels per input port.
REQ-002 SHALL have parameter BUFFER_SIZE, default 8, flits per VC buffer (power of two).
REQ-003 SHALL have parameter PORT_NUM, default 5, router ports, which also sets the out_port encoding range.
REQ-004 SHALL have port clk, input, 1 bit, the single clock.
REQ-005 SHALL have port rst, input, 1 bit, reset: synchronous, active-high.
REQ-006 SHALL have port wr_valid_i, input, 1 bit, an upstream flit is present this cycle.
REQ-007 SHALL have port wr_vc_i, input, VC_SIZE bits, the target VC of the incoming flit.
REQ-008 SHALL have port wr_flit_i, input, flit_t, the flit payload including its 2-bit flit type.
REQ-009 SHALL have port wr_out_port_i, input, PORT_SIZE bits, the routed output port, stored with every flit.
REQ-010 SHALL have port vc_request_o, input-side VC_NUM bits as an output, VA request per VC.
REQ-011 SHALL have port out_port_o, output, VC_NUM x PORT_SIZE bits, the output port of each VC's current packet.
REQ-012 SHALL have port vc_valid_i, input, VC_NUM bits, VA grant per VC.
REQ-013 SHALL have port vc_new_i, input, VC_NUM x VC_SIZE bits, the granted downstream VC id.
REQ-014 SHALL have port downstream_vc_o, output, VC_NUM x VC_SIZE bits, the latched downstream VC id.
REQ-015 SHALL have port sa_request_o, output, VC_NUM bits, switch-allocation request per VC.
REQ-016 SHALL have port rd_grant_i, input, VC_NUM bits, one-hot switch grant that pops that VC.
REQ-017 SHALL have port rd_flit_o, output, flit_t, the front flit of the granted VC, with the downstream VC id substituted.
REQ-018 SHALL have port idle_o, output, VC_NUM bits, registered "VC idle" indication toward the upstream VC allocator.
REQ-019 SHALL have port err_o, output, 1 bit, sticky protocol error (see Configuration).

Function
REQ-020 Each VC SHALL own a FIFO of BUFFER_SIZE entries holding {flit, out_port}; a write at cycle N SHALL become visible at the FIFO front at N+1.
REQ-021 A write to a full VC SHALL be dropped, leaving contents and count unchanged.
REQ-022 A simultaneous write and pop on the same VC SHALL leave the count unchanged, including when the FIFO is full.
REQ-023 Read and write pointers SHALL wrap modulo BUFFER_SIZE.
REQ-024 Each VC SHALL have a 3-state FSM: IDLE, VA, ACTIVE.
REQ-025 IDLE->VA SHALL occur when the FIFO front is a HEAD or HEADTAIL flit.
REQ-026 VA->ACTIVE SHALL occur on vc_valid_i; vc_new_i SHALL be latched into downstream_vc_o on the same edge.
REQ-027 ACTIVE->IDLE SHALL occur when a TAIL or HEADTAIL flit is popped.
REQ-028 vc_request_o[v] SHALL equal (state==VA), combinationally; out_port_o[v] SHALL be the front entry's out_port.
REQ-029 sa_request_o[v] SHALL equal (state==ACTIVE and FIFO non-empty).
REQ-030 rd_grant_i SHALL pop only when the VC's sa_request_o is high; otherwise the grant is ignored.
REQ-031 rd_flit_o SHALL be combinational from the granted VC's front entry; when no grant is present the output is don't-care.
REQ-032 idle_o[v] SHALL be registered: high one cycle after (state==IDLE and FIFO empty).
REQ-033 vc_valid_i to a VC not in VA SHALL be ignored.

Reset
REQ-034 On rst, all FIFOs SHALL be empty, all FSMs IDLE, downstream_vc_o=0, idle_o all ones, and err_o=0; reset mid-packet SHALL discard buffered flits.

Configuration
REQ-035 When IVC_ERR_FLAG_EN is defined, err_o SHALL set on a write to a full VC, an out-of-state vc_valid_i, or a non-one-hot rd_grant_i, and SHALL clear only on rst.
REQ-036 When IVC_ERR_FLAG_EN is undefined, err_o SHALL be tied 0 and no error logic SHALL exist; dropping and ignoring behaviour is unchanged.

Structure
REQ-037 flit_t, the flit-type enum (HEAD, BODY, TAIL, HEADTAIL), VC_SIZE and PORT_SIZE SHALL reside in noc_params.
REQ-038 The per-VC FIFO SHALL be a sub-module named ivc_fifo, instantiated VC_NUM times.

Verification
REQ-039 The bench SHALL cover: HEADTAIL to VC0 at cycle 0 -> vc_request_o[0]=1 at cycle 2; vc_valid_i[0] with vc_new=1 -> sa_request_o[0]=1 and downstream_vc_o[0]=1 next cycle; grant -> IDLE, with idle_o[0]=1 two cycles after the pop.
REQ-040 The bench SHALL cover: 9 writes to VC1 with BUFFER_SIZE=8 -> 8 stored, the 9th dropped, and err_o=1 when IVC_ERR_FLAG_EN is defined.
REQ-041 The bench SHALL cover: VC0 full with simultaneous write and pop for 20 cycles -> count stays 8, flit order is preserved and pointers wrap.
REQ-042 The bench SHALL cover: HEAD, BODY, TAIL, then HEAD of a new packet in VC0 -> after the TAIL pop the FSM passes IDLE then VA, idle_o stays 0, and the new out_port is shown.
REQ-043 The bench SHALL cover: vc_valid_i[1] while VC1 is IDLE -> no state change, downstream_vc_o[1] unchanged.
REQ-044 The bench SHALL cover: rst asserted in ACTIVE with 3 flits buffered -> next cycle all VCs IDLE, empty, idle_o=all ones.
